mdio_phy_responder: RTL and testbench

//  PHY-side MDIO (IEEE 802.3 clause 22) management responder: decodes frames from the MAC's MDC/MDIO master,

---
 rtl/mdio_pkg.sv | 37 +++
 rtl/mdio_edge_sync.sv | 41 ++++
 rtl/mdio_phy_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_mdio_phy_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// ============================================================================
//  mdio_pkg
//  Shared MDIO clause-22 codes, register map, defaults and FSM state type.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mdio_pkg;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam logic [4:0] REG_BMCR = 5'd0;
    localparam logic [4:0] REG_BMSR = 5'd1;
    localparam logic [4:0] REG_ID1  = 5'd2;
    localparam logic [4:0] REG_ID2  = 5'd3;
    localparam logic [4:0] REG_ANAR = 5'd4;

    localparam logic [15:0] BMCR_DEFAULT = 16'h3100;
    localparam logic [15:0] BMSR_BASE    = 16'h7809;
    localparam logic [15:0] ANAR_DEFAULT = 16'h01E1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ST    = 3'd2,
        S_OP    = 3'd3,
        S_PHYAD = 3'd4,
        S_REGAD = 3'd5,
        S_TA    = 3'd6,
        S_DATA  = 3'd7
    } mdio_state_t;

endpackage

`default_nettype wire

// File: rtl/mdio_edge_sync.sv
// ============================================================================
//  mdio_edge_sync
//  Synchronizes MDC/MDIO into clk and flags the synchronized MDC rising edge.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mdio_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc,
    input  logic mdio,
    output logic mdc_rise,
    output logic mdio_s
);

    logic [SYNC_STAGES-1:0] mdc_sync;
    logic [SYNC_STAGES-1:0] mdio_sync;
    logic                   mdc_prev;

    // MDIO goes through the same depth as MDC so setup relative to MDC is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_sync  <= '0;
            mdio_sync <= '1;
            mdc_prev  <= 1'b0;
        end else begin
            mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc};
            mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio};
            mdc_prev  <= mdc_sync[SYNC_STAGES-1];
        end
    end

    assign mdc_rise = mdc_sync[SYNC_STAGES-1] & ~mdc_prev;
    assign mdio_s   = mdio_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/mdio_phy_responder.sv
// ============================================================================
//  mdio_phy_responder
//  PHY-side MDIO clause-22 responder with a small register file.
//  Optional MDIO_EXT_REGS_EN: registers 16..31 become rw scratch.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd0,
    parameter int          SYNC_STAGES  = 2,
    parameter int          PREAMBLE_MIN = 32,
    parameter logic [15:0] RESET_HOLD   = 16'd1000,
    parameter logic [15:0] PHY_ID1      = 16'h0022,
    parameter logic [15:0] PHY_ID2      = 16'h1622
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_mdc,
    input  logic        i_mdio,
    output logic        o_mdio,
    output logic        o_mdio_oe,
    input  logic        i_link_up,
    output logic        o_soft_reset,
    output logic        o_reg_wr,
    output logic [4:0]  o_reg_addr,
    output logic [15:0] o_reg_wdata
);

    logic mdc_rise;
    logic mdio_bit;

    mdio_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdc      (i_mdc),
        .mdio     (i_mdio),
        .mdc_rise (mdc_rise),
        .mdio_s   (mdio_bit)
    );

    mdio_state_t state;
    logic [5:0]  cnt;
    logic [1:0]  op;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic        is_read;
    logic        is_match;
    logic [15:0] shreg;

    logic [15:0] bmcr;
    logic [15:0] anar;
    logic        link_bit;
    logic [15:0] hold_cnt;
`ifdef MDIO_EXT_REGS_EN
    logic [15:0] ext_regs [16];
`endif

    logic [1:0]  op_next;
    logic [4:0]  phy_next;
    logic [4:0]  reg_next;
    logic [15:0] rd_data;
    logic [15:0] wr_word;
    logic        data_last;
    logic        wr_commit;
    logic        bmsr_read_done;

    assign op_next   = {op[0], mdio_bit};
    assign phy_next  = {phyad[3:0], mdio_bit};
    assign reg_next  = {regad[3:0], mdio_bit};
    assign wr_word   = {shreg[14:0], mdio_bit};
    assign data_last = mdc_rise && (state == S_DATA) && (cnt == 6'd15) && is_match;
    assign wr_commit = data_last && !is_read;
    assign bmsr_read_done = data_last && is_read && (regad == REG_BMSR);

    always_comb begin
        rd_data = 16'h0000;
        case (reg_next)
            REG_BMCR: rd_data = {o_soft_reset, bmcr[14:0]};
            REG_BMSR: rd_data = BMSR_BASE | {13'd0, link_bit, 2'd0};
            REG_ID1:  rd_data = PHY_ID1;
            REG_ID2:  rd_data = PHY_ID2;
            REG_ANAR: rd_data = anar;
            default: begin
`ifdef MDIO_EXT_REGS_EN
                if (reg_next[4]) rd_data = ext_regs[reg_next[3:0]];
`endif
            end
        endcase
    end

    // Frame decoder; pin drive changes only on the clk following a sampled MDC rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op        <= '0;
            phyad     <= '0;
            regad     <= '0;
            is_read   <= 1'b0;
            is_match  <= 1'b0;
            shreg     <= '0;
            o_mdio    <= 1'b1;
            o_mdio_oe <= 1'b0;
        end else if (mdc_rise) begin
            case (state)
                S_IDLE: begin
                    if (!mdio_bit) begin
                        cnt <= '0;
                    end else if (int'(cnt) >= PREAMBLE_MIN - 1) begin
                        cnt   <= '0;
                        state <= S_PRE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_PRE: begin
                    if (mdio_bit == ST_CODE[1]) state <= S_ST;
                end
                S_ST: begin
                    cnt   <= '0;
                    state <= (mdio_bit == ST_CODE[0]) ? S_OP : S_IDLE;
                end
                S_OP: begin
                    op <= op_next;
                    if (cnt == 6'd1) begin
                        cnt     <= '0;
                        is_read <= (op_next == OP_READ);
                        state   <= (op_next == OP_READ || op_next == OP_WRITE) ? S_PHYAD : S_IDLE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_PHYAD: begin
                    phyad <= phy_next;
                    if (cnt == 6'd4) begin
                        cnt      <= '0;
                        is_match <= (phy_next == PHY_ADDR);
                        state    <= S_REGAD;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_REGAD: begin
                    regad <= reg_next;
                    if (cnt == 6'd4) begin
                        cnt   <= '0;
                        shreg <= rd_data;
                        state <= S_TA;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_TA: begin
                    if (cnt == 6'd0) begin
                        cnt <= 6'd1;
                        if (is_read && is_match) begin
                            o_mdio_oe <= 1'b1;
                            o_mdio    <= 1'b0;
                        end
                    end else begin
                        cnt   <= '0;
                        state <= S_DATA;
                        if (is_read && is_match) begin
                            o_mdio <= shreg[15];
                            shreg  <= {shreg[14:0], 1'b0};
                        end
                    end
                end
                S_DATA: begin
                    if (!is_read) begin
                        shreg <= wr_word;
                    end else if (cnt == 6'd15) begin
                        o_mdio_oe <= 1'b0;
                        o_mdio    <= 1'b1;
                    end else if (is_match) begin
                        o_mdio <= shreg[15];
                        shreg  <= {shreg[14:0], 1'b0};
                    end
                    if (cnt == 6'd15) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Register file; link bit starts cleared so the first BMSR read reports any pre-read loss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bmcr         <= BMCR_DEFAULT;
            anar         <= ANAR_DEFAULT;
            link_bit     <= 1'b0;
            hold_cnt     <= '0;
            o_soft_reset <= 1'b0;
            o_reg_wr     <= 1'b0;
            o_reg_addr   <= '0;
            o_reg_wdata  <= '0;
`ifdef MDIO_EXT_REGS_EN
            for (int i = 0; i < 16; i++) ext_regs[i] <= '0;
`endif
        end else begin
            o_reg_wr <= 1'b0;
            bmcr[9]  <= 1'b0;
            if (!i_link_up)          link_bit <= 1'b0;
            else if (bmsr_read_done) link_bit <= 1'b1;
            if (o_soft_reset) begin
                if (hold_cnt == 16'd0) o_soft_reset <= 1'b0;
                else                   hold_cnt     <= hold_cnt - 16'd1;
            end
            if (wr_commit) begin
                o_reg_wr    <= 1'b1;
                o_reg_addr  <= regad;
                o_reg_wdata <= wr_word;
                case (regad)
                    REG_BMCR: begin
                        if (!o_soft_reset) begin
                            if (wr_word[15]) begin
                                o_soft_reset <= 1'b1;
                                hold_cnt     <= RESET_HOLD - 16'd1;
                                bmcr         <= BMCR_DEFAULT;
                                anar         <= ANAR_DEFAULT;
`ifdef MDIO_EXT_REGS_EN
                                for (int i = 0; i < 16; i++) ext_regs[i] <= '0;
`endif
                            end else begin
                                bmcr <= {1'b0, wr_word[14:0]};
                            end
                        end
                    end
                    REG_ANAR: anar <= wr_word;
                    default: begin
`ifdef MDIO_EXT_REGS_EN
                        if (regad[4]) ext_regs[regad[3:0]] <= wr_word;
`endif
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdio_phy_responder.sv
// ============================================================================
//  tb_mdio_phy_responder
//  Directed MDIO master bench with read-data and write-strobe scoreboards.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mdio_phy_responder;

    localparam int MDC_HALF = 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_mdc;
    logic        i_link_up;
    logic        m_oe;
    logic        m_val;
    logic        mdio_pin;
    logic        o_mdio;
    logic        o_mdio_oe;
    logic        o_soft_reset;
    logic        o_reg_wr;
    logic [4:0]  o_reg_addr;
    logic [15:0] o_reg_wdata;

    int checks = 0;
    int errors = 0;
    int soft_cycles = 0;
    int oe_cycles = 0;
    int collisions = 0;
    logic samp_pin;
    logic samp_oe;
    logic prev_wr = 1'b0;

    logic [15:0] exp_q [$];
    logic [20:0] wr_q [$];

    assign mdio_pin = o_mdio_oe ? o_mdio : (m_oe ? m_val : 1'b1);

    mdio_phy_responder u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mdc        (i_mdc),
        .i_mdio       (mdio_pin),
        .o_mdio       (o_mdio),
        .o_mdio_oe    (o_mdio_oe),
        .i_link_up    (i_link_up),
        .o_soft_reset (o_soft_reset),
        .o_reg_wr     (o_reg_wr),
        .o_reg_addr   (o_reg_addr),
        .o_reg_wdata  (o_reg_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (o_soft_reset) soft_cycles++;
        if (o_mdio_oe) oe_cycles++;
        if (o_mdio_oe && m_oe) collisions++;
    end

    always @(negedge clk) begin : wr_monitor
        logic [20:0] e;
        if (rst_n && o_reg_wr) begin
            check("reg_wr_expected", wr_q.size() != 0, 1'b1);
            check("reg_wr_pulse_1clk", prev_wr, 1'b0);
            if (wr_q.size() != 0) begin
                e = wr_q.pop_front();
                check("reg_wr_addr", o_reg_addr, e[20:16]);
                check("reg_wr_wdata", o_reg_wdata, e[15:0]);
            end
        end
        prev_wr = o_reg_wr;
    end

    task automatic send_bit(input logic v, input logic drv);
        m_oe  = drv;
        m_val = v;
        #(MDC_HALF) i_mdc = 1'b1;
        samp_pin = mdio_pin;
        samp_oe  = o_mdio_oe;
        #(MDC_HALF) i_mdc = 1'b0;
    endtask

    task automatic send_header(input int npre, input logic [1:0] st, input logic [1:0] op,
                               input logic [4:0] pa, input logic [4:0] ra);
        for (int i = 0; i < npre; i++) send_bit(1'b1, 1'b1);
        for (int i = 1; i >= 0; i--) send_bit(st[i], 1'b1);
        for (int i = 1; i >= 0; i--) send_bit(op[i], 1'b1);
        for (int i = 4; i >= 0; i--) send_bit(pa[i], 1'b1);
        for (int i = 4; i >= 0; i--) send_bit(ra[i], 1'b1);
    endtask

    task automatic do_read(input string tag, input int npre, input logic [4:0] pa,
                           input logic [4:0] ra, input bit served, input logic [15:0] expv);
        logic [15:0] rd;
        logic ta1_oe, ta2_oe, ta2_pin;
        if (served) exp_q.push_back(expv);
        send_header(npre, 2'b01, 2'b10, pa, ra);
        send_bit(1'b1, 1'b0);
        ta1_oe = samp_oe;
        send_bit(1'b1, 1'b0);
        ta2_oe  = samp_oe;
        ta2_pin = samp_pin;
        for (int i = 15; i >= 0; i--) begin
            send_bit(1'b1, 1'b0);
            rd[i] = samp_pin;
        end
        if (served) begin
            check({tag, "_ta1_oe"}, ta1_oe, 1'b0);
            check({tag, "_ta2_oe"}, ta2_oe, 1'b1);
            check({tag, "_ta2_val"}, ta2_pin, 1'b0);
            check({tag, "_data"}, rd, exp_q.pop_front());
            check({tag, "_oe_after"}, o_mdio_oe, 1'b0);
        end
    endtask

    task automatic do_write(input string tag, input int npre, input logic [1:0] st,
                            input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                            input logic [15:0] wd, input bit strobe);
        if (strobe) wr_q.push_back({ra, wd});
        send_header(npre, st, op, pa, ra);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        for (int i = 15; i >= 0; i--) send_bit(wd[i], 1'b1);
        m_val = 1'b1;
        repeat (2) @(posedge clk);
        #1 check({tag, "_strobe_seen"}, wr_q.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int oe_before;
        int soft_before;
        logic [15:0] ext_exp;
        rst_n = 1'b0; i_mdc = 1'b0; i_link_up = 1'b1; m_oe = 1'b0; m_val = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mdio", o_mdio, 1'b1);
        check("rst_oe", o_mdio_oe, 1'b0);
        check("rst_soft_reset", o_soft_reset, 1'b0);
        check("rst_reg_wr", o_reg_wr, 1'b0);
        check("rst_reg_addr", o_reg_addr, 5'd0);
        check("rst_reg_wdata", o_reg_wdata, 16'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        do_read("rd_id1", 32, 5'd0, 5'd2, 1'b1, 16'h0022);
        do_read("rd_id2", 32, 5'd0, 5'd3, 1'b1, 16'h1622);
        do_read("rd_bmcr", 32, 5'd0, 5'd0, 1'b1, 16'h3100);
        do_read("rd_anar", 32, 5'd0, 5'd4, 1'b1, 16'h01E1);

        do_write("wr_anar", 32, 2'b01, 2'b01, 5'd0, 5'd4, 16'h0DE1, 1'b1);
        do_read("rd_anar_new", 32, 5'd0, 5'd4, 1'b1, 16'h0DE1);

        oe_before = oe_cycles;
        do_read("rd_short_pre", 31, 5'd0, 5'd2, 1'b0, 16'h0000);
        check("short_pre_no_oe", oe_cycles - oe_before, 0);
        oe_before = oe_cycles;
        do_read("rd_other_phy", 32, 5'd1, 5'd2, 1'b0, 16'h0000);
        check("other_phy_no_oe", oe_cycles - oe_before, 0);
        do_write("wr_other_phy", 32, 2'b01, 2'b01, 5'd1, 5'd4, 16'h1234, 1'b0);
        do_write("wr_bad_st", 32, 2'b00, 2'b01, 5'd0, 5'd4, 16'h0000, 1'b0);
        do_write("wr_bad_op", 32, 2'b01, 2'b00, 5'd0, 5'd4, 16'h0000, 1'b0);
        do_read("rd_after_ignored", 32, 5'd0, 5'd4, 1'b1, 16'h0DE1);

        i_link_up = 1'b0;
        repeat (10) @(posedge clk);
        i_link_up = 1'b1;
        do_read("rd_bmsr_latched", 32, 5'd0, 5'd1, 1'b1, 16'h7809);
        do_read("rd_bmsr_reload", 32, 5'd0, 5'd1, 1'b1, 16'h780D);

        do_write("wr_bmcr_an", 32, 2'b01, 2'b01, 5'd0, 5'd0, 16'h3300, 1'b1);
        do_read("rd_bmcr_an_clr", 32, 5'd0, 5'd0, 1'b1, 16'h3100);

        do_write("wr_unmapped", 32, 2'b01, 2'b01, 5'd0, 5'd10, 16'h1234, 1'b1);
        do_read("rd_unmapped", 32, 5'd0, 5'd10, 1'b1, 16'h0000);
`ifdef MDIO_EXT_REGS_EN
        ext_exp = 16'hA5A5;
`else
        ext_exp = 16'h0000;
`endif
        do_write("wr_ext20", 32, 2'b01, 2'b01, 5'd0, 5'd20, 16'hA5A5, 1'b1);
        do_read("rd_ext20", 32, 5'd0, 5'd20, 1'b1, ext_exp);

        soft_before = soft_cycles;
        do_write("wr_soft_rst", 32, 2'b01, 2'b01, 5'd0, 5'd0, 16'h8000, 1'b1);
        check("soft_reset_high", o_soft_reset, 1'b1);
        do_write("wr_soft_rst_again", 32, 2'b01, 2'b01, 5'd0, 5'd0, 16'h8000, 1'b1);
        repeat (1100) @(posedge clk);
        #1;
        check("soft_reset_len", soft_cycles - soft_before, 1000);
        check("soft_reset_done", o_soft_reset, 1'b0);
        do_read("rd_anar_dflt", 32, 5'd0, 5'd4, 1'b1, 16'h01E1);
        do_read("rd_bmcr_dflt", 32, 5'd0, 5'd0, 1'b1, 16'h3100);

        do_write("wr_soft_rst2", 32, 2'b01, 2'b01, 5'd0, 5'd0, 16'h8000, 1'b1);
        do_read("rd_bmcr_hold", 32, 5'd0, 5'd0, 1'b1, 16'hB100);
        repeat (600) @(posedge clk);
        do_read("rd_ext20_cleared", 32, 5'd0, 5'd20, 1'b1, 16'h0000);

        send_header(32, 2'b01, 2'b10, 5'd0, 5'd2);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        check("abort_oe_before", o_mdio_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_oe_released", o_mdio_oe, 1'b0);
        check("abort_mdio_idle", o_mdio, 1'b1);
        #20 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        do_read("rd_post_abort", 32, 5'd0, 5'd2, 1'b1, 16'h0022);

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_rd_empty", exp_q.size(), 0);
        check("scoreboard_wr_empty", wr_q.size(), 0);
        check("no_bus_contention", collisions, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
